// File: rtl/cpu_sram_responder.sv
// CPU-side single-port SRAM responder: 1-cycle reads, byte-lane writes, post-reset zero-fill.
// Optional macro SRAM_WRITE_FORWARD_EN selects write-first rdata on write cycles (default read-first).
module cpu_sram_responder #(
  parameter int ADDR_W = 10
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        en,
  input  logic [3:0]  wen,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        init_busy,
  output logic        oor_err
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    CLEAR,
    READY
  } state_t;

  state_t state, state_d;

  logic [ADDR_W-1:0] clr_ptr, clr_d;
  logic [31:0]       mem [DEPTH];

  logic [ADDR_W-1:0] idx;
  logic              oor;
  logic [31:0]       old_word;
  logic [31:0]       merged;
  logic [3:0]        we_be;
  logic [ADDR_W-1:0] waddr;
  logic [31:0]       wword;
  logic [31:0]       rdata_d;
  logic              oor_d;
  logic              busy_d;
  logic              unused;

  assign idx      = addr[ADDR_W+1:2];
  assign oor      = |addr[31:ADDR_W+2];
  assign old_word = mem[idx];
  assign unused   = ^addr[1:0];

  always_comb begin
    merged = old_word;
    for (int i = 0; i < 4; i++)
      if (wen[i]) merged[8*i +: 8] = wdata[8*i +: 8];
  end

  always_comb begin
    state_d = state;
    clr_d   = clr_ptr;
    we_be   = 4'h0;
    waddr   = clr_ptr;
    wword   = '0;
    rdata_d = rdata;
    oor_d   = 1'b0;
    unique case (state)
      CLEAR: begin
        we_be = 4'hF;
        clr_d = clr_ptr + 1'b1;
        if (&clr_ptr) state_d = READY;
      end
      READY: begin
        if (en) begin
          if (oor) begin
            rdata_d = '0;
            oor_d   = 1'b1;
          end else begin
            we_be = wen;
            waddr = idx;
            wword = wdata;
`ifdef SRAM_WRITE_FORWARD_EN
            rdata_d = merged;
`else
            rdata_d = old_word;
`endif
          end
        end
      end
      default: state_d = CLEAR;
    endcase
    busy_d = (state_d == CLEAR);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= CLEAR;
      clr_ptr   <= '0;
      rdata     <= '0;
      init_busy <= 1'b1;
      oor_err   <= 1'b0;
    end else begin
      state     <= state_d;
      clr_ptr   <= clr_d;
      rdata     <= rdata_d;
      init_busy <= busy_d;
      oor_err   <= oor_d;
    end
  end

  // Storage is left untouched while reset is held.
  always_ff @(posedge clk) begin
    if (resetn) begin
      for (int i = 0; i < 4; i++)
        if (we_be[i]) mem[waddr][8*i +: 8] <= wword[8*i +: 8];
    end
  end

endmodule

// File: tb/tb_cpu_sram_responder.sv
// Scoreboard bench for cpu_sram_responder: driver queues expected responses,
// monitor compares them one cycle after each sampled request.
module tb_cpu_sram_responder;

  logic        clk = 1'b0;
  logic        resetn;
  logic        en;
  logic [3:0]  wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        init_busy;
  logic        oor_err;

  cpu_sram_responder #(.ADDR_W(10)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .en        (en),
    .wen       (wen),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .init_busy (init_busy),
    .oor_err   (oor_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] rd;
    logic        oor;
    logic        busy;
    string       nm;
  } exp_t;

  exp_t sb[$];
  int   cyc  = 0;
  int   tot  = 0;
  int   pass = 0;
  bit   done = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tot++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        chk({e.nm, ".rdata"}, rdata, e.rd);
        chk({e.nm, ".oor"}, {31'b0, oor_err}, {31'b0, e.oor});
        chk({e.nm, ".busy"}, {31'b0, init_busy}, {31'b0, e.busy});
      end
    end
  end

  task automatic req(input logic e_, input logic [3:0] w,
                     input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] xr, input logic xo,
                     input logic xb, input string nm);
    exp_t e;
    en = e_; wen = w; addr = a; wdata = d;
    e.due = cyc + 1; e.rd = xr; e.oor = xo; e.busy = xb; e.nm = nm;
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic busy_count(input int start, input string nm);
    int n;
    n = start;
    while (init_busy && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk(nm, n, 1024);
  endtask

  localparam logic [31:0] W_DB  = 32'hDEADBEEF;
  localparam logic [31:0] W_M1  = 32'hDE223344;
  localparam logic [31:0] W_M2  = 32'hAB223344;

  initial begin
    resetn = 1'b0; en = 1'b0; wen = 4'h0; addr = '0; wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst.rdata", rdata, 32'h0);
    chk("rst.busy", {31'b0, init_busy}, 32'h1);
    chk("rst.oor", {31'b0, oor_err}, 32'h0);
    resetn = 1'b1;
    busy_count(0, "clear_len");

    req(1, 4'h0, 32'h0FFC, 0, 32'h0, 0, 0, "rd_ffc");
`ifdef SRAM_WRITE_FORWARD_EN
    req(1, 4'hF, 32'h10, W_DB, W_DB, 0, 0, "wr10");
`else
    req(1, 4'hF, 32'h10, W_DB, 32'h0, 0, 0, "wr10");
`endif
    req(1, 4'h0, 32'h10, 0, W_DB, 0, 0, "rd10");
`ifdef SRAM_WRITE_FORWARD_EN
    req(1, 4'b0111, 32'h10, 32'h11223344, W_M1, 0, 0, "wr10_lanes");
`else
    req(1, 4'b0111, 32'h10, 32'h11223344, W_DB, 0, 0, "wr10_lanes");
`endif
    req(1, 4'h0, 32'h10, 0, W_M1, 0, 0, "rd10_lanes");
    req(1, 4'h0, 32'h13, 0, W_M1, 0, 0, "rd13_unal");
`ifdef SRAM_WRITE_FORWARD_EN
    req(1, 4'b1000, 32'h10, 32'hAB000000, W_M2, 0, 0, "wr10_top");
`else
    req(1, 4'b1000, 32'h10, 32'hAB000000, W_M1, 0, 0, "wr10_top");
`endif
    req(1, 4'h0, 32'h10, 0, W_M2, 0, 0, "rd10_top");

    req(1, 4'hF, 32'h1000, 32'hFFFFFFFF, 32'h0, 1, 0, "oor_wr");
    req(1, 4'h0, 32'h0000, 0, 32'h0, 0, 0, "rd0_after_oor");
    req(1, 4'h0, 32'h10, 0, W_M2, 0, 0, "rd10_pre_oor");
    req(1, 4'h0, 32'hFFFF0000, 0, 32'h0, 1, 0, "oor_rd");
    req(0, 4'h0, 32'h0, 0, 32'h0, 0, 0, "idle_after_oor");

    req(1, 4'hF, 32'h20, 32'hA, 32'h0, 0, 0, "wr20");
    req(1, 4'hF, 32'h24, 32'hB, 32'h0, 0, 0, "wr24");
    req(1, 4'h0, 32'h20, 0, 32'hA, 0, 0, "rd20");
    req(1, 4'h0, 32'h24, 0, 32'hB, 0, 0, "rd24");
    for (int i = 0; i < 3; i++)
      req(0, 4'hF, 32'h20, 32'h77, 32'hB, 0, 0, $sformatf("hold%0d", i));

    en = 1'b0;
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    repeat (500) @(negedge clk);
    chk("midclr.busy", {31'b0, init_busy}, 32'h1);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    req(1, 4'hF, 32'h20, 32'h55, 32'h0, 0, 1, "clr_wr20");
    req(1, 4'h0, 32'h10, 0, 32'h0, 0, 1, "clr_rd10");
    req(1, 4'hF, 32'h4000, 32'h1, 32'h0, 0, 1, "clr_oor");
    en = 1'b0;
    busy_count(3, "reclear_len");

    req(1, 4'h0, 32'h20, 0, 32'h0, 0, 0, "post_rd20");
    req(1, 4'h0, 32'h24, 0, 32'h0, 0, 0, "post_rd24");
    req(1, 4'h0, 32'h10, 0, 32'h0, 0, 0, "post_rd10");
    req(1, 4'h0, 32'h0FFC, 0, 32'h0, 0, 0, "post_rdffc");
    en = 1'b0;
    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      tot++;
      $display("FAIL sb_drain: %0d left want 0", sb.size());
    end
    done = 1;
    $display("%0d/%0d checks passed", pass, tot);
    $finish;
  end

  initial begin
    #500000;
    if (!done) begin
      $display("FAIL timeout: done=0 want 1");
      $fatal(1, "timeout");
    end
  end

endmodule

// File: doc/cpu_sram_responder.md
Name: cpu_sram_responder

Overview:
Synchronous single-port SRAM responder serving the CPU side of the data/instruction SRAM interface (en, wen, addr, wdata, rdata).
- Services CPU reads and byte-lane writes with a fixed 1-cycle read latency.
- Zero-fills its storage after reset using an internal sweep state machine.
- Flags out-of-range accesses.
- Used as both the instruction memory and the data memory in the CPU test environment.

Parameters:
ADDR_W, 10, word-address width; depth DEPTH = 2**ADDR_W 32-bit words.

Ports:
clk  input  1  clock, all logic on rising edge
resetn  input  1  synchronous, active-low reset
en  input  1  access enable (read or write) from CPU
wen  input  4  byte write enables; wen[i] writes wdata[8i+7:8i]; 0 = read
addr  input  32  byte address from CPU
wdata  input  32  write data
rdata  output  32  registered read data
init_busy  output  1  high while the post-reset zero-fill runs
oor_err  output  1  one-cycle pulse: previous accepted access was out of range

Behaviour:
Reset, sampled at a clk edge while resetn=0:
- state<=CLEAR, clr_ptr<=0.
- rdata<=0, init_busy<=1, oor_err<=0.
- Memory contents are not touched during reset cycles.

State machine, two states, CLEAR and READY:
- CLEAR: each cycle writes mem[clr_ptr]<=0 and increments clr_ptr (ADDR_W bits).
- CLEAR to READY: on the edge where clr_ptr==DEPTH-1 is written. init_busy goes 0 on that same edge.
- CLEAR lasts exactly DEPTH cycles after resetn rises.
- CPU requests during CLEAR are ignored: no write, rdata holds 0, oor_err stays 0.
- READY: serves requests. Stays in READY until the next reset.
- resetn low mid-CLEAR: clr_ptr restarts at 0 and the sweep begins again after release.

Address decode:
- idx = addr[ADDR_W+1:2]; addr[1:0] ignored, so no alignment check.
- Out of range when addr[31:ADDR_W+2] != 0.

READY, en=1, wen=0 (read):
- rdata <= mem[idx] on the edge that samples the request.
- Data is visible the cycle after the request and is held until the next accepted access.
- Back-to-back reads give one result per cycle.

READY, en=1, wen!=0 (write):
- Only lanes with wen[i]=1 are updated; other bytes are unchanged.
- Any nonzero pattern is legal, including 4'b0111.
- rdata <= word contents before the write (read-first), unless the optional feature below is enabled.

READY, en=0:
- No memory change; rdata holds; oor_err<=0.

Out-of-range access in READY with en=1:
- Write suppressed.
- rdata<=0.
- oor_err<=1 for exactly one cycle, aligned with the rdata update.
- An in-range access or en=0 on the next cycle clears oor_err.

Other rules:
- Combinational paths: none from inputs to rdata. rdata is always a register.
- Arithmetic: clr_ptr wraps naturally at DEPTH-1. It is only advanced in CLEAR.

Optional Feature:
SRAM_WRITE_FORWARD_EN
- Defined: write-first. A write cycle returns the merged post-write word in rdata next cycle, i.e. new bytes for enabled lanes and old bytes elsewhere.
- Undefined: read-first as described above.
- Either way, a read of the same idx issued the cycle after a write returns the merged word.

Test Plan:
1. Zero-fill: hold resetn=0 for 2 cycles, release.
   -> init_busy=1 for exactly 1024 cycles (ADDR_W=10), then 0.
   -> A read at addr 0x0FFC then returns 0x00000000.
2. Full-word write then read: write addr 0x10, wen=4'hF, wdata=0xDEADBEEF; next cycle read 0x10.
   -> rdata=0xDEADBEEF one cycle after the read.
   -> During the write cycle rdata=0x00000000 (read-first), or 0xDEADBEEF with SRAM_WRITE_FORWARD_EN.
3. Byte lanes: after test 2, write 0x10 with wen=4'b0111, wdata=0x11223344; read 0x10.
   -> rdata=0xDE223344.
   -> Read of 0x13 also returns 0xDE223344, since addr[1:0] is ignored.
4. Out of range: write 0x1000 with wen=4'hF, wdata=0xFFFFFFFF.
   -> oor_err pulses 1 for one cycle, rdata=0.
   -> A following read of 0x0000 returns 0 and oor_err=0.
5. Reset mid-clear: assert resetn=0 at clear cycle 500, release after 1 cycle.
   -> init_busy stays 1 for a full 1024 cycles after release.
   -> Requests issued during that window leave rdata=0 and all words read back 0.
6. Hold and throughput: reads of 0x20 and 0x24 (preloaded 0xA, 0xB) on consecutive cycles, then en=0 for 3 cycles.
   -> rdata=0xA then 0xB on consecutive cycles, then holds 0xB for all 3 idle cycles.
